// File: rtl/genius_pkg.sv
// Shared definitions for the Genius (Simon) player-side logic:
// state encoding, colour codes and default widths.
package genius_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_PRESS   = 3'd1,
    CHECK        = 3'd2,
    WAIT_RELEASE = 3'd3,
    DONE         = 3'd4,
    ERROR        = 3'd5
  } state_t;

  localparam logic [3:0] RED    = 4'b0001;
  localparam logic [3:0] GREEN  = 4'b0010;
  localparam logic [3:0] BLUE   = 4'b0100;
  localparam logic [3:0] YELLOW = 4'b1000;

  // A valid press is exactly one colour; zero or several buttons are both errors.
  function automatic logic is_onehot(input logic [3:0] c);
    return (c != 4'b0000) && ((c & (c - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for the raw buttons plus an "any press" rising-edge
// detector on the synchronized vector.
module btn_sync_edge #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] btn_s_o,
  output logic         press_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Only a transition from all-released to something-pressed counts as a press.
  assign btn_s_o = sync_q;
  assign press_o = (sync_q != '0) && (prev_q == '0);

endmodule

// File: rtl/genius_user_checker.sv
// Walks the colour ROM while the player answers, checking each press and
// reporting round success (done) or failure (err) to the game controller.
module genius_user_checker
  import genius_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 250000000,
  parameter int unsigned TO_W           = 28
) (
  input  logic              clk,
  input  logic              R,
  input  logic              E,
  input  logic [ADDR_W-1:0] data,
  input  logic [3:0]        btn,
  input  logic [3:0]        rom_data,
  output logic [ADDR_W-1:0] SEQUSER,
  output logic              busy,
  output logic              hit,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] seq_q, seq_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [3:0]        cap_q, cap_d;
  logic              hit_q, hit_d;
  logic [3:0]        btn_s;
  logic              press;

  btn_sync_edge #(.W(4)) u_sync (
    .clk_i   (clk),
    .rst_ni  (R),
    .btn_i   (btn),
    .btn_s_o (btn_s),
    .press_o (press)
  );

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      seq_q   <= '0;
      timer_q <= '0;
      cap_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      timer_q <= timer_d;
      cap_q   <= cap_d;
      hit_q   <= hit_d;
    end
  end

  // Timeout takes priority over a press arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    timer_d = timer_q;
    cap_d   = cap_q;
    hit_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (E) begin
          seq_d   = '0;
          timer_d = '0;
          state_d = (data == '0) ? DONE : WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERROR;
        end else if (press) begin
          cap_d   = btn_s;
          timer_d = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!is_onehot(cap_q) || (cap_q != rom_data)) begin
          state_d = ERROR;
        end else begin
          hit_d   = 1'b1;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s == 4'b0000) begin
          if (seq_q == data - 1'b1) begin
            state_d = DONE;
          end else begin
            seq_d   = seq_q + 1'b1;
            state_d = WAIT_PRESS;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign SEQUSER = seq_q;
  assign hit     = hit_q;
  assign done    = (state_q == DONE);
  assign err     = (state_q == ERROR);
  assign busy    = (state_q == WAIT_PRESS) || (state_q == CHECK) ||
                   (state_q == WAIT_RELEASE);

endmodule

// File: tb/tb_genius_user_checker.sv
// Directed bench: stimulus pushes expected hit/done/err events into a queue,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_genius_user_checker;
  import genius_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned TO = 20;

  typedef enum logic [1:0] {EV_HIT, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct packed {
    ev_kind_t        kind;
    logic [AW-1:0]   seq;
  } ev_t;

  logic          clk = 1'b0;
  logic          R = 1'b0;
  logic          E = 1'b0;
  logic [AW-1:0] data = '0;
  logic [3:0]    btn = 4'b0000;
  logic [3:0]    rom_data;
  logic [AW-1:0] SEQUSER;
  logic          busy, hit, done, err;

  logic [3:0] rom [16];
  ev_t        expq[$];
  int         checks = 0;
  int         failures = 0;

  assign rom_data = rom[SEQUSER];

  genius_user_checker #(
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TO),
    .TO_W(5)
  ) dut (
    .clk(clk), .R(R), .E(E), .data(data), .btn(btn), .rom_data(rom_data),
    .SEQUSER(SEQUSER), .busy(busy), .hit(hit), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectEvent(input ev_kind_t k, input logic [AW-1:0] s);
    ev_t e;
    e.kind = k;
    e.seq  = s;
    expq.push_back(e);
  endtask

  // One-cycle start pulse, returning at the negedge after it was sampled.
  task automatic applyStimulus(input logic [AW-1:0] len);
    data = len;
    E = 1'b1;
    @(negedge clk);
    E = 1'b0;
  endtask

  task automatic pressButton(input logic [3:0] c);
    btn = c;
    repeat (5) @(negedge clk);
    btn = 4'b0000;
    repeat (5) @(negedge clk);
  endtask

  // Scoreboard monitor: hit pulses and rising done/err edges are events.
  logic doneP = 1'b0, errP = 1'b0;
  always @(negedge clk) begin
    ev_t      e;
    ev_kind_t k;
    logic     seen;
    if (R) begin
      seen = 1'b0;
      k = EV_HIT;
      if ((int'(hit) + int'(done) + int'(err)) > 1) begin
        checkOutput("exclusive_outputs", {29'd0, hit, done, err}, 32'd0);
      end
      if (hit) begin
        seen = 1'b1; k = EV_HIT;
      end else if (done && !doneP) begin
        seen = 1'b1; k = EV_DONE;
      end else if (err && !errP) begin
        seen = 1'b1; k = EV_ERR;
      end
      if (seen) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_event", 32'(k), 32'hFF);
        end else begin
          e = expq.pop_front();
          checkOutput("event_kind", 32'(k), 32'(e.kind));
          checkOutput("event_seq", 32'(SEQUSER), 32'(e.seq));
        end
      end
    end
    doneP = done & R;
    errP  = err & R;
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rom[i] = RED;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_err", 32'(err), 0);
    checkOutput("reset_seq", 32'(SEQUSER), 0);
    R = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] correct three-step round");
    rom[0] = RED; rom[1] = GREEN; rom[2] = BLUE;
    expectEvent(EV_HIT, 0); expectEvent(EV_HIT, 1); expectEvent(EV_HIT, 2);
    expectEvent(EV_DONE, 2);
    applyStimulus(3);
    checkOutput("start_busy", 32'(busy), 1);
    checkOutput("start_seq", 32'(SEQUSER), 0);
    pressButton(RED); pressButton(GREEN); pressButton(BLUE);
    checkOutput("r1_done", 32'(done), 1);
    checkOutput("r1_err", 32'(err), 0);
    checkOutput("r1_busy", 32'(busy), 0);

    $display("[TB] wrong colour");
    expectEvent(EV_ERR, 0);
    applyStimulus(3);
    checkOutput("restart_done_clr", 32'(done), 0);
    pressButton(GREEN);
    checkOutput("wrong_err", 32'(err), 1);
    checkOutput("wrong_seq", 32'(SEQUSER), 0);

    $display("[TB] two buttons at once");
    expectEvent(EV_ERR, 0);
    applyStimulus(2);
    pressButton(RED | BLUE);
    checkOutput("multi_err", 32'(err), 1);

    $display("[TB] timeout after first press");
    rom[0] = RED; rom[1] = GREEN;
    expectEvent(EV_HIT, 0); expectEvent(EV_ERR, 1);
    applyStimulus(2);
    btn = RED;
    repeat (5) @(negedge clk);
    btn = 4'b0000;
    n = 0;
    while (SEQUSER != 1 && n < 50) begin
      @(negedge clk); n++;
    end
    checkOutput("timeout_reach_seq1", 32'(SEQUSER), 1);
    n = 0;
    while (!err && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("timeout_cycles", 32'(n), TO);
    @(negedge clk);
    checkOutput("timeout_seq", 32'(SEQUSER), 1);

    $display("[TB] zero-length round then restart");
    expectEvent(EV_DONE, 0);
    applyStimulus(0);
    checkOutput("zero_done", 32'(done), 1);
    checkOutput("zero_err", 32'(err), 0);
    rom[0] = RED;
    expectEvent(EV_HIT, 0); expectEvent(EV_DONE, 0);
    applyStimulus(1);
    checkOutput("restart_done", 32'(done), 0);
    checkOutput("restart_busy", 32'(busy), 1);
    checkOutput("restart_seq", 32'(SEQUSER), 0);
    E = 1'b1; data = 4'd3;
    @(negedge clk);
    E = 1'b0;
    checkOutput("busy_ignores_E", 32'(busy), 1);
    data = 4'd1;
    pressButton(RED);
    checkOutput("len1_done", 32'(done), 1);

    $display("[TB] async reset mid-round and held button");
    rom[0] = RED; rom[1] = GREEN; rom[2] = BLUE; rom[3] = YELLOW;
    expectEvent(EV_HIT, 0); expectEvent(EV_HIT, 1);
    applyStimulus(4);
    pressButton(RED); pressButton(GREEN);
    checkOutput("mid_seq", 32'(SEQUSER), 2);
    @(posedge clk); #2;
    R = 1'b0;
    #1;
    checkOutput("areset_outputs", {27'd0, SEQUSER, busy, hit, done, err}, 0);
    btn = RED;
    @(negedge clk);
    R = 1'b1;
    repeat (5) @(negedge clk);
    rom[0] = RED;
    applyStimulus(1);
    repeat (5) @(negedge clk);
    checkOutput("held_no_hit_busy", 32'(busy), 1);
    checkOutput("held_no_hit_queue", 32'(expq.size()), 0);
    btn = 4'b0000;
    repeat (3) @(negedge clk);
    expectEvent(EV_HIT, 0); expectEvent(EV_DONE, 0);
    pressButton(RED);
    checkOutput("held_then_done", 32'(done), 1);

    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    checkOutput("queue_drained", 32'(expq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
